result_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous result memory between two requesters:
//   - the processor's result stream (40-bit word plus enable strobe);
//   - a host/debug reader.

---
 rtl/result_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_result_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_mem_arbiter.sv
// result_mem_arbiter: buffers processor result words in a small FIFO and shares one
// single-port result RAM between FIFO drains and host reads, round-robin.
module result_mem_arbiter #(
    parameter int DATA_W = 40,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_valid,
    input  logic [DATA_W-1:0] proc_data,
    output logic              proc_stall,
    output logic              overflow,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] wr_count,
    output logic              wrapped
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    typedef enum logic [1:0] {IDLE, WR, RD, RD_DATA} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] fifo_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic              last_host_q, overflow_q, host_ack_q, mem_we_q, mem_re_q, wrapped_q;
    logic [DATA_W-1:0] host_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q, wr_count_q;
    logic              full, pop, push, host_pend, grant_wr, grant_rd;

    always_comb begin
        full      = count_q == FULL_CNT;
        pop       = state_q == WR;
        push      = proc_valid && (!full || pop);
        // the ack cycle is still IDLE; the held request there belongs to the read just finished
        host_pend = host_req && !host_ack_q;
        grant_wr  = full || (count_q != '0 && (!host_pend || last_host_q));
        grant_rd  = host_pend && !grant_wr;
        count_d   = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= proc_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            last_host_q  <= 1'b1;
            overflow_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wr_count_q   <= '0;
            wrapped_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            overflow_q <= overflow_q || (proc_valid && !push);
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            host_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_wr) begin
                        state_q     <= WR;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_count_q;
                        mem_wdata_q <= fifo_q[rd_ptr_q];
                    end else if (grant_rd) begin
                        state_q    <= RD;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= host_addr;
                    end
                end
                WR: begin
                    wr_count_q  <= wr_count_q + 1'b1;
                    wrapped_q   <= wrapped_q || (&wr_count_q);
                    last_host_q <= 1'b0;
                    state_q     <= IDLE;
                end
                RD: state_q <= RD_DATA;
                default: begin
                    host_rdata_q <= mem_rdata;
                    host_ack_q   <= 1'b1;
                    last_host_q  <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign proc_stall = full;
    assign overflow   = overflow_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign wr_count   = wr_count_q;
    assign wrapped    = wrapped_q;
endmodule

// File: tb/tb_result_mem_arbiter.sv
// tb_result_mem_arbiter: directed, table-driven bench with a 1-cycle-latency RAM model
// and hand-computed expectations for reset, streaming, overflow, contention and wrap.
module tb_result_mem_arbiter;
    localparam int DW = 40;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          proc_valid = 1'b0;
    logic [DW-1:0] proc_data = '0;
    logic          proc_stall, overflow, host_ack, mem_we, mem_re, wrapped;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr, wr_count;

    always #5 clk = ~clk;

    result_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .proc_valid(proc_valid), .proc_data(proc_data), .proc_stall(proc_stall), .overflow(overflow),
        .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wr_count(wr_count), .wrapped(wrapped)
    );

    logic [DW-1:0] ram [2**AW];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    int   checks = 0;
    int   errors = 0;
    logic [AW+DW-1:0] wlog[$];
    byte  oplog[$];
    bit   stall_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_we) begin
                wlog.push_back({mem_addr, mem_wdata});
                oplog.push_back("W");
            end
            if (mem_re) oplog.push_back("R");
            if (mem_we && mem_re) begin
                errors++;
                $display("FAIL we_re_exclusive: got we=1 re=1 required not both");
            end
            if (proc_stall) stall_seen = 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output int lat, output logic [DW-1:0] d);
        host_addr = a;
        host_req  = 1'b1;
        lat = 0;
        while (!host_ack && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = host_rdata;
        host_req = 1'b0;
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (int'(wr_count) != target && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        proc_valid = 1'b1;
        proc_data  = d;
        @(negedge clk);
        proc_valid = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            lat;
    } rd_vec_t;

    rd_vec_t       rv[5];
    logic [DW-1:0] sw[3];
    initial begin
        int            lat, base;
        logic [DW-1:0] d;
        bit            seen;
        string         exp_ops;
        rv[0] = '{12'd5,    40'hAB_CDEF_0123, 3};
        rv[1] = '{12'd0,    40'h00_0000_0000, 3};
        rv[2] = '{12'd4095, 40'hFF_FFFF_FFFF, 3};
        rv[3] = '{12'd100,  40'h5A_A5A5_5A5A, 3};
        rv[4] = '{12'd6,    40'h12_3456_789A, 3};
        sw[0] = 40'h01_0000_0001;
        sw[1] = 40'h02_0000_0002;
        sw[2] = 40'h03_0000_0003;
        exp_ops = "RWWRWRWRW";

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // T1: asynchronous reset while a read is in flight
        host_addr = 12'd9;
        host_req  = 1'b1;
        @(negedge clk);
        chk("t1_re_before_reset", mem_re, 1);
        #2 rst = 1'b0;
        #1;
        chk("t1_mem_re", mem_re, 0);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 0);
        chk("t1_mem_wdata", mem_wdata, 0);
        chk("t1_host_ack", host_ack, 0);
        chk("t1_host_rdata", host_rdata, 0);
        chk("t1_flags", {proc_stall, overflow, wrapped}, 0);
        chk("t1_wr_count", wr_count, 0);
        host_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (host_ack || mem_re || mem_we) seen = 1;
        end
        chk("t1_idle_no_ack", seen, 0);

        // T2: three consecutive words, no host traffic
        wlog.delete();
        for (int i = 0; i < 3; i++) begin
            proc_valid = 1'b1;
            proc_data  = sw[i];
            @(negedge clk);
        end
        proc_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_nwrites", wlog.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t2_write%0d", i), (i < wlog.size()) ? wlog[i] : '0, {12'(i), sw[i]});
        chk("t2_wr_count", wr_count, 3);
        chk("t2_overflow", overflow, 0);

        // T4: table of uncontended host reads
        for (int i = 0; i < 5; i++) begin
            preload(rv[i].addr, rv[i].data);
            host_read(rv[i].addr, lat, d);
            chk($sformatf("rd%0d_latency", i), lat, rv[i].lat);
            chk($sformatf("rd%0d_data", i), d, rv[i].data);
            repeat (2) @(negedge clk);
        end

        // T5: one FIFO word and a host request pending together, last grant host
        wlog.delete();
        oplog.delete();
        proc_valid = 1'b1;
        proc_data  = 40'h55_0000_00AA;
        @(negedge clk);
        proc_valid = 1'b0;
        host_read(12'd5, lat, d);
        chk("t5_latency", lat, 5);
        chk("t5_data", d, 40'hAB_CDEF_0123);
        chk("t5_first_op", (oplog.size() > 0) ? oplog[0] : 8'd0, "W");
        chk("t5_second_op", (oplog.size() > 1) ? oplog[1] : 8'd0, "R");
        chk("t5_write", (wlog.size() > 0) ? wlog[0] : '0, {12'd3, 40'h55_0000_00AA});
        repeat (4) @(negedge clk);

        // T3: six back-to-back words against a continuous host request
        wlog.delete();
        oplog.delete();
        stall_seen = 0;
        base = int'(wr_count);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    proc_valid = 1'b1;
                    proc_data  = 40'h30_0000_0000 + 40'(i);
                    @(negedge clk);
                end
                proc_valid = 1'b0;
            end
            begin
                int n = 0;
                host_addr = 12'd100;
                host_req  = 1'b1;
                @(negedge clk);
                wait_wr(base + 5);
                while (!host_ack && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk("t3_final_ack", host_ack, 1);
                chk("t3_final_rdata", host_rdata, 40'h5A_A5A5_5A5A);
                host_req = 1'b0;
            end
        join
        repeat (6) @(negedge clk);
        chk("t3_stall_seen", stall_seen, 1);
        chk("t3_overflow", overflow, 1);
        chk("t3_wr_count", wr_count, 12'(base + 5));
        chk("t3_nwrites", wlog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t3_write%0d", i), (i < wlog.size()) ? wlog[i] : '0,
                {12'(base + i), 40'h30_0000_0000 + 40'(i)});
        for (int i = 0; i < 9; i++)
            chk($sformatf("t3_op%0d", i), (i < oplog.size()) ? oplog[i] : 8'd0, exp_ops[i]);

        // T6: wr_count rollover
        rst = 1'b0;
        #1;
        chk("t6_reset_overflow", overflow, 0);
        chk("t6_reset_wr_count", wr_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4095; i++) send_word(40'(i));
        wait_wr(4095);
        chk("t6_pre_count", wr_count, 4095);
        chk("t6_pre_wrapped", wrapped, 0);
        repeat (3) @(negedge clk);
        wlog.delete();
        send_word(40'hEE_0000_0001);
        send_word(40'hEE_0000_0002);
        wait_wr(1);
        repeat (4) @(negedge clk);
        chk("t6_write_last", (wlog.size() > 0) ? wlog[0] : '0, {12'd4095, 40'hEE_0000_0001});
        chk("t6_write_zero", (wlog.size() > 1) ? wlog[1] : '0, {12'd0, 40'hEE_0000_0002});
        chk("t6_wrapped", wrapped, 1);
        chk("t6_wr_count", wr_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
